// File: rtl/coeff_bank_regfile.sv
// -----------------------------------------------------------------------------
// coeff_bank_regfile
//   APB register file holding NUM_BANKS banks of BANK_DEPTH signed coefficients.
//   Software writes a shadow copy; a COMMIT write copies the selected banks to
//   the active copy that drives the filter datapath, all at one clock edge.
//
//   Address map (CB = NUM_BANKS*BANK_DEPTH):
//     0..CB-1  shadow coefficient b*BANK_DEPTH+k (read sign-extended)
//     CB       COMMIT  (W: bank mask, R: 0)
//     CB+1     ENABLE  (RW, drives BANK_EN)
//     CB+2     STATUS  (RO, sticky "bank committed since reset")
//     CB+3     LOCK    (only with COEFF_LOCK_EN)
//     others   invalid: PSLVERR=1, read pattern 0xAAAA...
//
//   Optional feature macro: COEFF_LOCK_EN
//     defined   - LOCK[0]=1 blocks coefficient and COMMIT writes (PSLVERR=1).
//     undefined - LOCK reads 0, writes accepted with OKAY and ignored.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     PSEL, PENABLE,
//     PWRITE, PADDR,
//     PWDATA            APB request
//     PRDATA, PREADY,
//     PSLVERR           APB response (registered, valid only in ACCESS)
//     COEFF_OUT         active coefficients, flattened
//     BANK_VLD          one-cycle pulse per committed bank
//     BANK_EN           per-bank enable
// -----------------------------------------------------------------------------
module coeff_bank_regfile #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_DEPTH  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      PSEL,
  input  logic                                      PENABLE,
  input  logic                                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]                     PADDR,
  input  logic [DATA_WIDTH-1:0]                     PWDATA,
  output logic [DATA_WIDTH-1:0]                     PRDATA,
  output logic                                      PREADY,
  output logic                                      PSLVERR,
  output logic [NUM_BANKS*BANK_DEPTH*COEFF_WIDTH-1:0] COEFF_OUT,
  output logic [NUM_BANKS-1:0]                      BANK_VLD,
  output logic [NUM_BANKS-1:0]                      BANK_EN
);

  localparam int CB          = NUM_BANKS * BANK_DEPTH;
  localparam int IDX_W       = (CB > 1) ? $clog2(CB) : 1;
  localparam int ADDR_COMMIT = CB;
  localparam int ADDR_ENABLE = CB + 1;
  localparam int ADDR_STATUS = CB + 2;
  localparam int ADDR_LOCK   = CB + 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  apb_state_e               state_r;
  logic [COEFF_WIDTH-1:0]   shadow_r [CB];
  logic [COEFF_WIDTH-1:0]   active_r [CB];
  logic [NUM_BANKS-1:0]     enable_r;
  logic [NUM_BANKS-1:0]     status_r;
  logic [NUM_BANKS-1:0]     bank_vld_r;
  logic [DATA_WIDTH-1:0]    prdata_r;
  logic                     pready_r;
  logic                     pslverr_r;

  // Write intent captured on entry to ACCESS, applied at the edge ending it.
  logic                     wr_coeff_r;
  logic                     wr_commit_r;
  logic                     wr_enable_r;
  logic [IDX_W-1:0]         idx_r;
  logic [DATA_WIDTH-1:0]    wdata_r;

  logic [31:0]              paddr_ext_s;
  logic [IDX_W-1:0]         idx_s;
  logic                     is_coeff_s;
  logic                     is_commit_s;
  logic                     is_enable_s;
  logic                     is_status_s;
  logic                     is_lock_s;
  logic                     invalid_s;
  logic                     locked_s;
  logic                     err_s;
  logic [DATA_WIDTH-1:0]    rdata_s;
  logic                     in_access_s;
  logic                     unused_ok_s;

`ifdef COEFF_LOCK_EN
  logic                     lock_r;
  logic                     wr_lock_r;
`endif

  // Address decode, error classification and read mux on the live APB request.
  always_comb begin
    paddr_ext_s = 32'(PADDR);
    idx_s       = PADDR[IDX_W-1:0];
    is_coeff_s  = (paddr_ext_s < 32'(CB));
    is_commit_s = (paddr_ext_s == 32'(ADDR_COMMIT));
    is_enable_s = (paddr_ext_s == 32'(ADDR_ENABLE));
    is_status_s = (paddr_ext_s == 32'(ADDR_STATUS));
    is_lock_s   = (paddr_ext_s == 32'(ADDR_LOCK));
    invalid_s   = (paddr_ext_s > 32'(ADDR_LOCK));
`ifdef COEFF_LOCK_EN
    locked_s    = lock_r;
`else
    locked_s    = 1'b0;
`endif
    err_s = invalid_s
          | (PWRITE & is_status_s)
          | (PWRITE & locked_s & (is_coeff_s | is_commit_s));

    rdata_s = {DATA_WIDTH{1'b0}};
    if (is_coeff_s) begin
      rdata_s = DATA_WIDTH'($signed(shadow_r[idx_s]));
    end else if (is_enable_s) begin
      rdata_s = DATA_WIDTH'(enable_r);
    end else if (is_status_s) begin
      rdata_s = DATA_WIDTH'(status_r);
    end else if (is_lock_s) begin
`ifdef COEFF_LOCK_EN
      rdata_s = DATA_WIDTH'(lock_r);
`else
      rdata_s = {DATA_WIDTH{1'b0}};
`endif
    end else if (invalid_s) begin
      rdata_s = {(DATA_WIDTH/2){2'b10}};
    end else begin
      // COMMIT reads as zero.
      rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign in_access_s = (state_r == ST_ACCESS);
  // Only the low bits of the write data are ever stored; the rest is don't-care.
  assign unused_ok_s = ^wdata_r;

  // APB state machine with registered response; write intent latched on SETUP->ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      prdata_r    <= {DATA_WIDTH{1'b0}};
      wr_coeff_r  <= 1'b0;
      wr_commit_r <= 1'b0;
      wr_enable_r <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
`ifdef COEFF_LOCK_EN
      wr_lock_r   <= 1'b0;
`endif
    end else begin
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      prdata_r    <= {DATA_WIDTH{1'b0}};
      wr_coeff_r  <= 1'b0;
      wr_commit_r <= 1'b0;
      wr_enable_r <= 1'b0;
`ifdef COEFF_LOCK_EN
      wr_lock_r   <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (!PSEL) begin
            // Master abandoned the transfer: nothing is latched.
            state_r <= ST_IDLE;
          end else if (PENABLE) begin
            state_r     <= ST_ACCESS;
            pready_r    <= 1'b1;
            pslverr_r   <= err_s;
            prdata_r    <= PWRITE ? {DATA_WIDTH{1'b0}} : rdata_s;
            wr_coeff_r  <= PWRITE & ~err_s & is_coeff_s;
            wr_commit_r <= PWRITE & ~err_s & is_commit_s;
            wr_enable_r <= PWRITE & ~err_s & is_enable_s;
            idx_r       <= idx_s;
            wdata_r     <= PWDATA;
`ifdef COEFF_LOCK_EN
            wr_lock_r   <= PWRITE & ~err_s & is_lock_s;
`endif
          end else begin
            state_r <= ST_SETUP;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Register writes and bank commit, performed at the edge that ends ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CB; i++) begin
        shadow_r[i] <= {COEFF_WIDTH{1'b0}};
        active_r[i] <= {COEFF_WIDTH{1'b0}};
      end
      enable_r   <= {NUM_BANKS{1'b0}};
      status_r   <= {NUM_BANKS{1'b0}};
      bank_vld_r <= {NUM_BANKS{1'b0}};
`ifdef COEFF_LOCK_EN
      lock_r     <= 1'b0;
`endif
    end else begin
      bank_vld_r <= {NUM_BANKS{1'b0}};
      if (in_access_s && wr_coeff_r) begin
        shadow_r[idx_r] <= wdata_r[COEFF_WIDTH-1:0];
      end
      if (in_access_s && wr_enable_r) begin
        enable_r <= wdata_r[NUM_BANKS-1:0];
      end
      if (in_access_s && wr_commit_r) begin
        // Mask bits above NUM_BANKS are simply never looked at.
        bank_vld_r <= wdata_r[NUM_BANKS-1:0];
        status_r   <= status_r | wdata_r[NUM_BANKS-1:0];
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (wdata_r[b]) begin
            for (int k = 0; k < BANK_DEPTH; k++) begin
              active_r[b*BANK_DEPTH+k] <= shadow_r[b*BANK_DEPTH+k];
            end
          end
        end
      end
`ifdef COEFF_LOCK_EN
      if (in_access_s && wr_lock_r) begin
        lock_r <= wdata_r[0];
      end
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CB; gi++) begin : g_coeff_out
      assign COEFF_OUT[gi*COEFF_WIDTH +: COEFF_WIDTH] = active_r[gi];
    end
  endgenerate

  assign PRDATA   = prdata_r;
  assign PREADY   = pready_r;
  assign PSLVERR  = pslverr_r;
  assign BANK_VLD = bank_vld_r;
  assign BANK_EN  = enable_r;

endmodule
